// File: rtl/mmio_bus_interconnect_if.sv
// Load/store bus between the core, the interconnect and its peripheral channels.
// The interconnect takes the slave view; the core/peripheral side takes the master view.
interface mmio_bus_interconnect_if #(
    parameter int NUM_SLAVES = 2,
    parameter int AW         = 32,
    parameter int DW         = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [AW-1:0]            req_addr;
    logic [DW-1:0]            req_wdata;
    logic                     rsp_valid;
    logic [DW-1:0]            rsp_rdata;
    logic                     rsp_err;
    logic [NUM_SLAVES-1:0]    s_sel;
    logic                     s_we;
    logic [AW-1:0]            s_addr;
    logic [DW-1:0]            s_wdata;
    logic [NUM_SLAVES*DW-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]    s_ack;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, s_rdata, s_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, s_sel, s_we, s_addr, s_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, s_rdata, s_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, s_sel, s_we, s_addr, s_wdata
    );
endinterface

// File: rtl/mmio_bus_interconnect.sv
// Memory-mapped interconnect: base/mask decode, one outstanding access, ack handshake,
// error response for unmapped addresses and an optional bus timeout.
module mmio_bus_interconnect #(
    parameter int                       NUM_SLAVES = 2,
    parameter int                       AW         = 32,
    parameter int                       DW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = {32'hFFFF_FF00, 32'hFFFF_F000},
    parameter int                       TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mmio_bus_interconnect_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [NUM_SLAVES-1:0] hit;
    logic [AW-1:0]         offs [NUM_SLAVES];
    logic                  dec_hit;
    logic [IW-1:0]         dec_idx;
    logic                  ack_sel;
    logic [DW-1:0]         sel_rdata;

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
        assign hit[gi]  = (bus.req_addr & SLAVE_MASK[gi*AW +: AW]) == SLAVE_BASE[gi*AW +: AW];
        assign offs[gi] = bus.req_addr & ~SLAVE_MASK[gi*AW +: AW];
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_hit = 1'b1;
                dec_idx = IW'(i);
            end
        end
    end

    assign ack_sel   = bus.s_ack[idx_q];
    assign sel_rdata = bus.s_rdata[idx_q*DW +: DW];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        idx_d       = idx_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                        sel_d   = NUM_SLAVES'(1) << dec_idx;
                        idx_d   = dec_idx;
                        we_d    = bus.req_we;
                        addr_d  = offs[dec_idx];
                        wdata_d = bus.req_wdata;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rdata_d     = '0;
                        err_d       = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack in the final timeout cycle still completes the access normally.
                if (ack_sel) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = we_q ? '0 : sel_rdata;
                    err_d       = 1'b0;
                    sel_d       = '0;
                    we_d        = 1'b0;
                    cnt_d       = '0;
                end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    sel_d       = '0;
                    we_d        = 1'b0;
                    cnt_d       = '0;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.s_sel     = sel_q;
    assign bus.s_we      = we_q;
    assign bus.s_addr    = addr_q;
    assign bus.s_wdata   = wdata_q;
endmodule
